// File: rtl/cal_norm_sched_if.sv
// Requester-side bus of cal_norm_sched: per-channel request levels and operands,
// one-hot acknowledge and the shared result return path.
interface cal_norm_sched_if #(
  parameter int unsigned NCH = 8
);
  localparam int unsigned ChW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]    req;
  logic [16*NCH-1:0] req_curr;
  logic [16*NCH-1:0] req_per;
  logic [NCH-1:0]    ack;
  logic              res_valid;
  logic [ChW-1:0]    res_ch;
  logic [15:0]       res_data;

  modport master (
    output req, req_curr, req_per,
    input  ack, res_valid, res_ch, res_data
  );

  modport slave (
    input  req, req_curr, req_per,
    output ack, res_valid, res_ch, res_data
  );
endinterface

// File: rtl/cal_norm_sched.sv
// Round-robin sequencer sharing one fixed-latency cal_norm unit between NCH channels.
// Optional CAL_SCHED_ZERO_BYPASS_EN: a zero period skips the normaliser and returns 16'hFFFF.
module cal_norm_sched #(
  parameter int unsigned NCH      = 8,
  parameter int unsigned NORM_LAT = 300
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cal_norm_sched_if.slave        bus,
  output logic                   busy,
  output logic                   norm_go,
  output logic [15:0]            norm_curr,
  output logic [15:0]            norm_per,
  input  logic [15:0]            norm_result
);
  localparam int unsigned ChW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CntW = (NORM_LAT > 1) ? $clog2(NORM_LAT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(NORM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ChW-1:0]  last_q, last_d;
  logic [ChW-1:0]  cur_ch_q, cur_ch_d;
  logic [15:0]     norm_curr_q, norm_curr_d;
  logic [15:0]     norm_per_q, norm_per_d;
  logic [15:0]     res_data_q, res_data_d;
  logic [ChW-1:0]  res_ch_q, res_ch_d;

  logic           any_req;
  logic [ChW-1:0] grant;
  logic [15:0]    sel_curr;
  logic [15:0]    sel_per;

  assign any_req = |bus.req;

  // Later iterations win, so the channel right after last_q has top priority.
  always_comb begin
    int unsigned idx;
    grant = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = (32'(last_q) + NCH - i) % NCH;
      if (bus.req[idx[ChW-1:0]]) grant = idx[ChW-1:0];
    end
  end

  assign sel_curr = bus.req_curr[{grant, 4'b0000} +: 16];
  assign sel_per  = bus.req_per[{grant, 4'b0000} +: 16];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    cur_ch_d    = cur_ch_q;
    norm_curr_d = norm_curr_q;
    norm_per_d  = norm_per_q;
    res_data_d  = res_data_q;
    res_ch_d    = res_ch_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          cur_ch_d    = grant;
          norm_curr_d = sel_curr;
          norm_per_d  = sel_per;
          state_d     = StIssue;
`ifdef CAL_SCHED_ZERO_BYPASS_EN
          if (sel_per == 16'd0) begin
            state_d    = StCapture;
            res_data_d = 16'hFFFF;
            res_ch_d   = grant;
          end
`endif
        end
      end
      StIssue: begin
        cnt_d   = CntLoad;
        state_d = StWait;
      end
      StWait: begin
        // Result is registered on the way into CAPTURE so it is valid alongside ack.
        if (cnt_q == '0) begin
          state_d    = StCapture;
          res_data_d = norm_result;
          res_ch_d   = cur_ch_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StCapture: begin
        last_d  = cur_ch_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_q      <= ChW'(NCH - 1);
      cur_ch_q    <= '0;
      norm_curr_q <= '0;
      norm_per_q  <= '0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      cur_ch_q    <= cur_ch_d;
      norm_curr_q <= norm_curr_d;
      norm_per_q  <= norm_per_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign norm_go       = (state_q == StIssue);
  assign norm_curr     = norm_curr_q;
  assign norm_per      = norm_per_q;
  assign bus.res_valid = (state_q == StCapture);
  assign bus.ack       = (state_q == StCapture) ? (NCH'(1) << cur_ch_q) : '0;
  assign bus.res_data  = res_data_q;
  assign bus.res_ch    = res_ch_q;
endmodule

// File: tb/tb_cal_norm_sched.sv
// Directed bench for cal_norm_sched with a fixed-latency stub normaliser (curr - per).
module tb_cal_norm_sched;
  localparam int unsigned NCH      = 8;
  localparam int unsigned NORM_LAT = 300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic        norm_go;
  logic [15:0] norm_curr;
  logic [15:0] norm_per;
  logic [15:0] norm_result;

  always #5 clk = ~clk;

  cal_norm_sched_if #(.NCH(NCH)) bus ();

  cal_norm_sched #(
    .NCH      (NCH),
    .NORM_LAT (NORM_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .norm_go     (norm_go),
    .norm_curr   (norm_curr),
    .norm_per    (norm_per),
    .norm_result (norm_result)
  );

  // Stub normaliser: result only becomes valid NORM_LAT cycles after go.
  int          stub_cnt;
  logic [15:0] stub_val;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt <= 0;
      stub_val <= 16'h0;
    end else if (norm_go) begin
      stub_cnt <= 1;
      stub_val <= norm_curr - norm_per;
    end else if (stub_cnt != 0 && stub_cnt < int'(NORM_LAT)) begin
      stub_cnt <= stub_cnt + 1;
    end
  end
  assign norm_result = (stub_cnt >= int'(NORM_LAT)) ? stub_val : 16'hDEAD;

  int          cyc = 0;
  int          go_cnt = 0;
  int          ack_cnt = 0;
  int          go_cyc[$];
  logic [15:0] go_curr, go_per;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (norm_go) begin
      go_cnt++;
      go_cyc.push_back(cyc);
      go_curr = norm_curr;
      go_per  = norm_per;
    end
    if (|bus.ack) ack_cnt++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [15:0] curr, input logic [15:0] per);
    bus.req_curr[16*k +: 16] = curr;
    bus.req_per[16*k +: 16]  = per;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_curr = '0;
    bus.req_per  = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_result(output int cycles, output int idle);
    cycles = 0;
    idle   = 0;
    do begin
      step();
      cycles++;
      if (!busy) idle++;
    end while (!bus.res_valid && cycles < 1000);
    check("res_valid_seen", 32'(bus.res_valid), 32'd1);
  endtask

  function automatic logic [15:0] golden(input logic [15:0] curr, input logic [15:0] per);
    return curr - per;
  endfunction

  int order[6] = '{0, 2, 7, 0, 2, 7};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat, idl, t0, g0, a0, first;
    bus.req      = '0;
    bus.req_curr = '0;
    bus.req_per  = '0;
    step();
    step();
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_go",        32'(norm_go),       32'd0);
    check("rst_ack",       32'(bus.ack),       32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_ch",    32'(bus.res_ch),    32'd0);
    check("rst_res_data",  32'(bus.res_data),  32'd0);
    check("rst_norm_curr", 32'(norm_curr),     32'd0);
    check("rst_norm_per",  32'(norm_per),      32'd0);
    rst_n = 1'b1;
    step();

    // Single request on channel 0.
    set_ch(0, 16'd61000, 16'd100);
    bus.req[0] = 1'b1;
    t0 = cyc;
    g0 = go_cnt;
    wait_result(lat, idl);
    check("single_lat",      32'(lat),          32'd302);
    check("single_ack",      32'(bus.ack),      32'h01);
    check("single_res_data", 32'(bus.res_data), 32'd60900);
    check("single_res_ch",   32'(bus.res_ch),   32'd0);
    check("single_go_cnt",   32'(go_cnt - g0),  32'd1);
    check("single_go_cyc",   32'(go_cyc[$] - t0), 32'd1);
    check("single_go_curr",  32'(go_curr),      32'd61000);
    check("single_go_per",   32'(go_per),       32'd100);
    bus.req = '0;
    step();
    check("single_idle_busy", 32'(busy),    32'd0);
    check("single_ack_pulse", 32'(bus.ack), 32'd0);
    step();
    check("single_no_regrant", 32'(busy), 32'd0);

    // Round-robin between channels 0, 2 and 7.
    do_reset();
    for (int k = 0; k < int'(NCH); k++) set_ch(k, 16'(1000 * (k + 1)), 16'(10 * (k + 1)));
    go_cyc.delete();
    bus.req = 8'b1000_0101;
    for (int i = 0; i < 6; i++) begin
      wait_result(lat, idl);
      check($sformatf("rr_ch_%0d", i),   32'(bus.res_ch),  32'(order[i]));
      check($sformatf("rr_ack_%0d", i),  32'(bus.ack),     32'(1 << order[i]));
      check($sformatf("rr_data_%0d", i), 32'(bus.res_data),
            32'(golden(16'(1000 * (order[i] + 1)), 16'(10 * (order[i] + 1)))));
      if (i == 5) bus.req = '0;
    end
    check("rr_go_count", 32'(go_cyc.size()), 32'd6);
    for (int i = 1; i < go_cyc.size(); i++)
      check($sformatf("rr_go_gap_%0d", i), 32'(go_cyc[i] - go_cyc[i-1]), 32'd303);

    // Operand isolation: operand changes after the grant are ignored.
    do_reset();
    set_ch(3, 16'd5000, 16'd150);
    bus.req = 8'b0000_1000;
    repeat (50) step();
    set_ch(3, 16'd7777, 16'd999);
    step();
    check("iso_norm_per",  32'(norm_per),  32'd150);
    check("iso_norm_curr", 32'(norm_curr), 32'd5000);
    wait_result(lat, idl);
    check("iso_res_data", 32'(bus.res_data), 32'd4850);
    check("iso_res_ch",   32'(bus.res_ch),   32'd3);
    check("iso_hold_per", 32'(norm_per),     32'd150);
    bus.req = '0;

    // Reset abort 100 cycles into WAIT, then pending ch1 served first.
    do_reset();
    set_ch(1, 16'd3000, 16'd30);
    set_ch(4, 16'd4000, 16'd40);
    bus.req = 8'b0001_0010;
    repeat (101) step();
    check("abort_busy_pre", 32'(busy), 32'd1);
    a0 = ack_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_busy",      32'(busy),          32'd0);
    check("abort_go",        32'(norm_go),       32'd0);
    check("abort_ack",       32'(bus.ack),       32'd0);
    check("abort_res_valid", 32'(bus.res_valid), 32'd0);
    check("abort_norm_curr", 32'(norm_curr),     32'd0);
    check("abort_norm_per",  32'(norm_per),      32'd0);
    step();
    step();
    check("abort_no_ack", 32'(ack_cnt - a0), 32'd0);
    rst_n = 1'b1;
    wait_result(lat, idl);
    check("abort_lat",      32'(lat),          32'd302);
    check("abort_res_ch",   32'(bus.res_ch),   32'd1);
    check("abort_res_data", 32'(bus.res_data), 32'd2970);
    check("abort_ack_once", 32'(ack_cnt - a0), 32'd1);
    bus.req = '0;

    // Zero period on channel 5.
    do_reset();
    set_ch(5, 16'd1234, 16'd0);
    g0 = go_cnt;
    bus.req = 8'b0010_0000;
    wait_result(lat, idl);
    check("zero_ack",    32'(bus.ack),    32'h20);
    check("zero_res_ch", 32'(bus.res_ch), 32'd5);
`ifdef CAL_SCHED_ZERO_BYPASS_EN
    check("zero_lat",      32'(lat),          32'd1);
    check("zero_res_data", 32'(bus.res_data), 32'hFFFF);
    check("zero_go_cnt",   32'(go_cnt - g0),  32'd0);
`else
    check("zero_lat",      32'(lat),          32'd302);
    check("zero_res_data", 32'(bus.res_data), 32'd1234);
    check("zero_go_cnt",   32'(go_cnt - g0),  32'd1);
`endif
    bus.req = '0;

    // Period sweep on channel 0 with back-to-back requests.
    do_reset();
    first = 1;
    for (int p = 100; p <= 293; p += 7) begin
      set_ch(0, 16'd61000, 16'(p));
      bus.req[0] = 1'b1;
      wait_result(lat, idl);
      check($sformatf("sweep_data_%0d", p), 32'(bus.res_data), 32'(golden(16'd61000, 16'(p))));
      if (first == 0) begin
        check($sformatf("sweep_idle_%0d", p), 32'(idl), 32'd1);
        check($sformatf("sweep_lat_%0d", p),  32'(lat), 32'd303);
      end
      first = 0;
    end
    bus.req = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
